// File: rtl/shift_rows_if.sv
// Stream bus for the ShiftRows stage: input beat (valid/ready/mode/data/tag)
// and output beat (valid/ready/data/tag).
interface shift_rows_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;

    // Producer of input beats and consumer of output beats
    modport master (
        output in_valid, in_mode, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // The ShiftRows block itself
    modport slave (
        input  in_valid, in_mode, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/shift_rows_stream.sv
// Streaming AES/Rijndael ShiftRows (forward, inverse or bypass per beat) for
// NB = 4..8 columns, with a 2-entry output FIFO on a valid/ready handshake.
module shift_rows_stream #(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    shift_rows_if.slave   bus
);
    localparam int unsigned DATA_W = 32 * NB;
    localparam int unsigned S1     = 1;
    localparam int unsigned S2     = (NB == 8) ? 3 : 2;
    localparam int unsigned S3     = (NB >= 7) ? 4 : 3;

    // Reject unsupported block widths at elaboration
    generate
        if (NB < 4 || NB > 8) begin : g_bad_nb
            $error("shift_rows_stream: NB must be in 4..8");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("shift_rows_stream: TAG_W must be at least 1");
        end
    endgenerate

    // Rijndael row offset for row r
    function automatic int unsigned row_shift(input int unsigned r);
        case (r)
            1:       return S1;
            2:       return S2;
            3:       return S3;
            default: return 0;
        endcase
    endfunction

    // Column of the input byte that lands in column c of row r
    function automatic int unsigned src_col(input int unsigned c, input int unsigned r,
                                            input logic inv);
        if (inv) return (c + NB - row_shift(r)) % NB;
        return (c + row_shift(r)) % NB;
    endfunction

    logic [DATA_W-1:0] perm_c;
    logic              push_c;
    logic              pop_c;

    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];
    logic [TAG_W-1:0]  tag_q  [2];
    logic [TAG_W-1:0]  tag_d  [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q,  count_d;

    // Byte permutation of the incoming state; mode[1] selects bypass
    always_comb begin
        perm_c = bus.in_data;
        if (!bus.in_mode[1]) begin
            for (int unsigned c = 0; c < NB; c++) begin
                for (int unsigned r = 0; r < 4; r++) begin
                    perm_c[8*(4*c+r) +: 8] =
                        bus.in_data[8*(4*src_col(c, r, bus.in_mode[0])+r) +: 8];
                end
            end
        end
    end

    assign push_c = bus.in_valid && bus.in_ready;
    assign pop_c  = bus.out_valid && bus.out_ready;

    // FIFO next state: write permuted beat at tail, advance head on pop
    always_comb begin
        data_d   = data_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + 2'(push_c) - 2'(pop_c);
        if (push_c) begin
            data_d[wr_ptr_q] = perm_c;
            tag_d[wr_ptr_q]  = bus.in_tag;
            wr_ptr_d         = !wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = !rd_ptr_q;
        end
    end

    // FIFO state registers; reset discards all buffered beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            data_q   <= data_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Handshake and head-of-queue outputs, from registered state only
    assign bus.in_ready  = (count_q != 2'd2) && !rst;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = data_q[rd_ptr_q];
    assign bus.out_tag   = tag_q[rd_ptr_q];
endmodule
